// File: rtl/cfg_loader.sv
// cfg_loader: streams 4*NUM_BLOCKS config bytes into the x/y/ab/cx registers of each logic block
module cfg_loader #(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            cfg_out,
    output logic [NUM_BLOCKS-1:0] set_x,
    output logic [NUM_BLOCKS-1:0] set_y,
    output logic [NUM_BLOCKS-1:0] set_ab,
    output logic [NUM_BLOCKS-1:0] set_cx,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      blk_idx
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;
    state_t                r_state, w_next;
    logic [IDX_W-1:0]      r_blk;
    logic [1:0]            r_sel;
    logic [7:0]            r_cfg;
    logic [NUM_BLOCKS-1:0] r_x, r_y, r_ab, r_cx;
    logic                  w_acc, w_last;
    logic [NUM_BLOCKS-1:0] w_hot;
    assign in_ready = (r_state == S_LOAD) && !abort;
    assign w_acc    = in_ready && in_valid;
    assign w_last   = (r_blk == IDX_W'(NUM_BLOCKS - 1)) && (r_sel == 2'd3);
    assign w_hot    = NUM_BLOCKS'(1) << r_blk;
    assign busy     = r_state == S_LOAD;
    assign done     = r_state == S_FIN;
    assign blk_idx  = r_blk;
    assign cfg_out  = r_cfg;
    assign set_x    = r_x;
    assign set_y    = r_y;
    assign set_ab   = r_ab;
    assign set_cx   = r_cx;
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    // next state: FIN always lasts a single cycle, abort only matters in LOAD
    always_comb begin
        w_next = (r_state == S_IDLE) ? (start ? S_LOAD : S_IDLE) :
                 (r_state == S_FIN)  ? S_IDLE :
                 abort               ? S_IDLE :
                 (w_acc && w_last)   ? S_FIN  : S_LOAD;
    end
    // sequencing and registered write strobes, one cycle after each accepted byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk <= '0;
            r_sel <= '0;
            r_cfg <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_ab  <= '0;
            r_cx  <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_blk <= '0;
                r_sel <= '0;
            end else if (w_acc) begin
                r_sel <= r_sel + 2'd1;
                if (r_sel == 2'd3) r_blk <= w_last ? '0 : r_blk + 1'b1;
            end
            if (w_acc) r_cfg <= in_data;
            r_x  <= (w_acc && r_sel == 2'd0) ? w_hot : '0;
            r_y  <= (w_acc && r_sel == 2'd1) ? w_hot : '0;
            r_ab <= (w_acc && r_sel == 2'd2) ? w_hot : '0;
            r_cx <= (w_acc && r_sel == 2'd3) ? w_hot : '0;
        end
    end
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed checks of cfg_loader with four blocks
module tb_cfg_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, busy, done;
    logic [7:0] cfg_out;
    logic [3:0] set_x, set_y, set_ab, set_cx;
    logic [1:0] blk_idx;
    logic [15:0] w_stb;
    int n_chk = 0;
    int n_err = 0;

    cfg_loader #(.NUM_BLOCKS(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_out(cfg_out), .set_x(set_x), .set_y(set_y), .set_ab(set_ab),
        .set_cx(set_cx), .busy(busy), .done(done), .blk_idx(blk_idx)
    );

    assign w_stb = {set_cx, set_ab, set_y, set_x};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // byte k of a frame targets block k/4, register k%4 (x,y,ab,cx)
    function automatic logic [31:0] exp_stb(input int k);
        return 32'(1) << ((k % 4) * 4 + k / 4);
    endfunction

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // send bytes first..last of a frame, optionally with two idle cycles after each
    task automatic send(input int first, input int last, input logic [7:0] base, input bit thr);
        for (int k = first; k <= last; k++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(k);
            cyc();
            in_valid = 1'b0;
            check("stb", w_stb, exp_stb(k));
            check("cfg", 32'(cfg_out), 32'(base + 8'(k)));
            check("done", 32'(done), (k == 15) ? 32'd1 : 32'd0);
            if (thr) begin
                for (int j = 0; j < 2; j++) begin
                    cyc();
                    check("idle_stb", w_stb, 32'd0);
                    check("idle_cfg", 32'(cfg_out), 32'(base + 8'(k)));
                end
            end
        end
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_stb", w_stb, 32'd0);
        check("rst_cfg", 32'(cfg_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_blk", 32'(blk_idx), 32'd0);
        rst_n = 1'b1;
        // 1: back-to-back frame
        go();
        check("load_rdy", 32'(in_ready), 32'd1);
        send(0, 15, 8'h10, 1'b0);
        check("fin_busy", 32'(busy), 32'd0);
        cyc();
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_stb", w_stb, 32'd0);
        check("post_cfg", 32'(cfg_out), 32'h1F);
        // 2: throttled frame
        go();
        send(0, 15, 8'h10, 1'b1);
        // 3: start during LOAD is ignored; start in FIN also ignored
        go();
        send(0, 4, 8'h20, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("mid_start_blk", 32'(blk_idx), 32'd1);
        check("mid_start_stb", w_stb, 32'd0);
        check("mid_start_busy", 32'(busy), 32'd1);
        send(5, 15, 8'h20, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("fin_start_busy", 32'(busy), 32'd0);
        check("fin_start_rdy", 32'(in_ready), 32'd0);
        // 4: abort after 6 bytes with a byte on offer
        go();
        send(0, 5, 8'h40, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        #1;
        check("abort_rdy", 32'(in_ready), 32'd0);
        cyc();
        abort = 1'b0;
        check("abort_stb", w_stb, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idle_rdy", 32'(in_ready), 32'd0);
        check("abort_cfg", 32'(cfg_out), 32'h45);
        cyc();
        in_valid = 1'b0;
        check("abort2_stb", w_stb, 32'd0);
        check("abort2_done", 32'(done), 32'd0);
        go();
        send(0, 0, 8'h42, 1'b0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort3_busy", 32'(busy), 32'd0);
        // 5: reset mid-frame at block 2
        go();
        send(0, 7, 8'h60, 1'b0);
        check("pre_rst_blk", 32'(blk_idx), 32'd2);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        cyc();
        rst_n    = 1'b1;
        check("mrst_stb", w_stb, 32'd0);
        check("mrst_cfg", 32'(cfg_out), 32'd0);
        check("mrst_blk", 32'(blk_idx), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        go();
        send(0, 15, 8'h30, 1'b0);
        // 6: byte offered with start in IDLE is not taken
        cyc();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        cyc();
        start = 1'b0;
        check("s6_stb", w_stb, 32'd0);
        check("s6_busy", 32'(busy), 32'd1);
        in_data = 8'h55;
        cyc();
        in_valid = 1'b0;
        check("s6_stb55", w_stb, exp_stb(0));
        check("s6_cfg55", 32'(cfg_out), 32'h55);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cfg_loader.md
Name: cfg_loader

Overview:
- Configuration writer that drives the per-block config port (`cfg_in` bus plus `set_x`/`set_y`/`set_ab`/`set_cx` strobes) of every logic block in the array.
- Accepts a byte stream through a valid/ready handshake fed from the chip input pins.
- Walks blocks 0..NUM_BLOCKS-1 in order. For each block it writes four registers in the fixed order x, y, ab, cx.
- Reports busy/done so the top level can gate user operation until the fabric is programmed.

Parameters:
- NUM_BLOCKS, 8: number of logic blocks driven; valid range 1..16.
- IDX_W, 3: width of the block index; must equal clog2(NUM_BLOCKS), minimum 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to begin a full configuration frame
- abort  input  1  abandon the frame in progress
- in_data  input  8  config byte from pins
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept in_data this cycle
- cfg_out  output  8  byte broadcast to all blocks' cfg_in
- set_x  output  NUM_BLOCKS  per-block x-register write strobe
- set_y  output  NUM_BLOCKS  per-block y-register write strobe
- set_ab  output  NUM_BLOCKS  per-block ab-register write strobe
- set_cx  output  NUM_BLOCKS  per-block cx-register write strobe
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse when a frame completes
- blk_idx  output  IDX_W  block currently being loaded

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All set_* = 0, cfg_out = 0, in_ready = 0, busy = 0, done = 0, blk_idx = 0.
  - The internal register selector reg_sel (0=x, 1=y, 2=ab, 3=cx) = 0.
  - Reset overrides start, abort and in_valid.
- States:
  - IDLE: in_ready=0, busy=0. When start=1: go to LOAD with blk_idx=0 and reg_sel=0.
  - LOAD: in_ready=1 unless abort=1. busy=1.
  - FIN: one cycle only. done=1, busy=0, in_ready=0. Then go to IDLE.
- Accept rule: a byte is accepted on a clk edge where state=LOAD, in_valid=1 and in_ready=1. Without abort, throughput is one byte per cycle.
- Write latency: exactly 1 cycle after acceptance.
  - cfg_out is registered and holds the accepted byte.
  - Exactly one strobe bit is 1 for exactly one cycle: the bit at index blk_idx (value at acceptance) in set_x, set_y, set_ab or set_cx, chosen by reg_sel.
  - All other strobe bits are 0 in every cycle. Strobes are never more than one-hot across all four vectors.
  - cfg_out keeps its last value when no strobe is active.
- Sequencing on each accept:
  - reg_sel increments.
  - When reg_sel wraps from 3 to 0, blk_idx increments.
- Frame end: accepting the byte with blk_idx=NUM_BLOCKS-1 and reg_sel=3 moves the state to FIN. The final strobe and done=1 occur in the same cycle.
- Frame length: exactly 4*NUM_BLOCKS bytes.
- in_valid=0 in LOAD: nothing happens and the state is held indefinitely. There is no timeout.
- start outside IDLE is ignored, including in FIN. start in the cycle after FIN (state IDLE) begins a new frame.
- start and in_valid in the same IDLE cycle: the frame starts, but the byte is not accepted because in_ready=0 in IDLE.
- abort=1 in LOAD:
  - No byte is accepted that cycle.
  - No strobe is issued for any later byte.
  - State goes to IDLE; done is not pulsed.
  - Registers already written stay written.
- abort in IDLE or FIN has no effect.
- Reset mid-frame: the frame is discarded and the next cycle shows the reset values. The blocks reload their own defaults from the same reset.
- NUM_BLOCKS not a power of two: blk_idx never exceeds NUM_BLOCKS-1, and no strobe bit beyond NUM_BLOCKS-1 exists.

Test Plan:
1. Full frame, NUM_BLOCKS=4: start, then 16 bytes 0x10..0x1F back-to-back with in_valid=1.
   - set_x[0] with cfg_out=0x10 appears 1 cycle after the first accept.
   - Each following cycle, one strobe advances through set_y[0], set_ab[0], set_cx[0], set_x[1], … up to set_cx[3] with cfg_out=0x1F.
   - done=1 in the same cycle as set_cx[3]; busy=0 the next cycle.
2. Throttled input: same frame with in_valid toggling 1,0,0,1…
   - Strobes appear only 1 cycle after accepting edges, in the same order and with the same byte values as scenario 1.
   - No strobe appears on idle cycles.
3. start pulsed during LOAD after 5 bytes: blk_idx and reg_sel are unchanged (blk_idx=1, reg_sel=1); the frame completes after 11 more bytes.
4. abort after 6 bytes, with in_valid=1 in the abort cycle:
   - No 7th strobe is issued; done is never pulsed.
   - State returns to IDLE with in_ready=0 the next cycle.
   - A fresh start then writes set_x[0] first.
5. rst_n=0 for one cycle mid-frame (blk_idx=2): all outputs are 0 the next cycle and state is IDLE. A subsequent start plus 16 bytes completes a normal frame.
6. start and in_valid=1 with in_data=0xAA in the same IDLE cycle: no strobe is issued for 0xAA. The next accepted byte 0x55 drives set_x[0] with cfg_out=0x55.
